// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: instruction FIFO, 4x4 register file and operator issue/writeback.
// Optional zero_flag output is enabled by defining SEQ_ZERO_FLAG_EN.
module alu_issue_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int OP_LAT     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_instr,
  output logic       in_ready,
  input  logic       reg_wr_en,
  input  logic [1:0] reg_wr_addr,
  input  logic [3:0] reg_wr_data,
  output logic       reg_wr_ready,
  output logic [7:0] instr,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic [3:0] dato_mux,
  output logic       res_valid,
  output logic [3:0] res_data,
`ifdef SEQ_ZERO_FLAG_EN
  output logic       zero_flag,
`endif
  output logic       busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] WAIT_LD  = CW'(OP_LAT - 1);
  localparam logic [CW-1:0] WAIT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [7:0]    word;
  logic [CW-1:0] cnt;
  logic [3:0]    regs [4];
  logic          push;
  logic          pop;
  logic          host_wr;

  assign in_ready     = (count != FULL_CNT);
  assign push         = in_valid && in_ready;
  assign pop          = (state == IDLE) && (count != '0);
  assign reg_wr_ready = (state != WB);
  assign host_wr      = reg_wr_en && reg_wr_ready;
  assign busy         = (state != IDLE) || (count != '0);

  // FIFO storage; entries need no reset since validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  // Register file: writeback wins; host writes are refused during WB
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (state == WB && word[0]) begin
      regs[word[4:3]] <= dato_mux;
    end else if (host_wr) begin
      regs[reg_wr_addr] <= reg_wr_data;
    end
  end

  // Sequencer: pop, drive operator inputs, hold for OP_LAT, capture result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word      <= '0;
      instr     <= '0;
      A         <= '0;
      B         <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
`ifdef SEQ_ZERO_FLAG_EN
      zero_flag <= 1'b0;
`endif
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            word  <= mem[rd_ptr];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          instr <= word;
          A     <= regs[word[4:3]];
          B     <= regs[word[2:1]];
          cnt   <= WAIT_LD;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) state <= WB;
          else           cnt   <= cnt - WAIT_ONE;
        end
        WB: begin
          res_data  <= dato_mux;
          res_valid <= 1'b1;
`ifdef SEQ_ZERO_FLAG_EN
          zero_flag <= (dato_mux == 4'h0);
`endif
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: scoreboard of expected results in push order,
// checked by a negedge monitor; operator modelled as an opcode-selected function.
module tb_alu_issue_sequencer;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_instr = '0;
  logic       in_ready;
  logic       reg_wr_en = 1'b0;
  logic [1:0] reg_wr_addr = '0;
  logic [3:0] reg_wr_data = '0;
  logic       reg_wr_ready;
  logic [7:0] instr;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] dato_mux;
  logic       res_valid;
  logic [3:0] res_data;
  logic       busy;
`ifdef SEQ_ZERO_FLAG_EN
  logic       zero_flag;
`endif

  always #5 clk = ~clk;

  alu_issue_sequencer #(.FIFO_DEPTH(DEPTH), .OP_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_instr(in_instr),
    .in_ready(in_ready),
    .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .reg_wr_ready(reg_wr_ready),
    .instr(instr),
    .A(A),
    .B(B),
    .dato_mux(dato_mux),
    .res_valid(res_valid),
    .res_data(res_data),
`ifdef SEQ_ZERO_FLAG_EN
    .zero_flag(zero_flag),
`endif
    .busy(busy)
  );

  typedef struct packed {
    logic [7:0] w;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r;
  } exp_t;

  exp_t        sbq[$];
  int          pulses[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          stab = 0;
  logic [15:0] prev_ops = '0;
  logic [15:0] cur_ops;
  exp_t        e;
  logic [3:0]  mr [4];

  function automatic logic [3:0] opf(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a;
      3'd6: return b;
      default: return ~a;
    endcase
  endfunction

  // operator: result only meaningful once inputs have been stable long enough
  always_comb begin
    dato_mux = opf(instr[7:5], A, B);
    if (stab < LAT + 1) dato_mux = ~opf(instr[7:5], A, B);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // monitor: track input stability and check each result against the scoreboard
  always @(negedge clk) begin
    cur_ops = {instr, A, B};
    if (cur_ops == prev_ops) stab++;
    else stab = 1;
    prev_ops = cur_ops;
    if (!rst && res_valid) begin
      pulses.push_back(cyc);
      if (sbq.size() == 0) begin
        chk("unexpected_res_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("res_data", res_data, e.r);
        chk("instr", instr, e.w);
        chk("A", A, e.a);
        chk("B", B, e.b);
        chk("hold", stab >= LAT + 2, 1);
`ifdef SEQ_ZERO_FLAG_EN
        chk("zero_flag", zero_flag, e.r == 4'h0);
`endif
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [7:0] w);
    exp_t x;
    x.w = w;
    x.a = mr[w[4:3]];
    x.b = mr[w[2:1]];
    x.r = opf(w[7:5], x.a, x.b);
    if (w[0]) mr[w[4:3]] = x.r;
    sbq.push_back(x);
  endtask

  task automatic offer(input logic [7:0] w, output logic acc);
    in_instr = w;
    in_valid = 1'b1;
    acc = in_ready;
    if (acc) enq(w);
    step();
    in_valid = 1'b0;
  endtask

  task automatic hostw(input logic [1:0] a, input logic [3:0] d);
    int n;
    n = 0;
    reg_wr_en = 1'b1;
    reg_wr_addr = a;
    reg_wr_data = d;
    while (!reg_wr_ready && n < 50) begin
      step();
      n++;
    end
    chk("host_wr_timeout", n < 50, 1);
    step();
    mr[a] = d;
    reg_wr_en = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((busy || sbq.size() > 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  task automatic wait_wb;
    int n;
    n = 0;
    while (reg_wr_ready && n < 40) begin
      step();
      n++;
    end
    chk("wb_block_seen", reg_wr_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic       acc;
  logic [4:0] accbits;
  logic [7:0] w;
  int         nb;

  initial begin
    for (int i = 0; i < 4; i++) mr[i] = '0;
    // reset
    rst = 1'b1;
    step();
    step();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_instr", instr, 0);
    chk("rst_wr_ready", reg_wr_ready, 1);
`ifdef SEQ_ZERO_FLAG_EN
    chk("rst_zero_flag", zero_flag, 0);
`endif
    rst = 1'b0;
    step();

    // basic add with writeback, then read back R0
    hostw(2'd0, 4'd3);
    hostw(2'd1, 4'd5);
    offer(8'b000_00_01_1, acc);
    wait_idle();
    offer(8'b000_00_00_0, acc);
    wait_idle();

    // FIFO fill while busy: 4 accepted, 5th dropped, strict spacing
    pulses.delete();
    offer(8'b100_00_01_0, acc);
    step();
    for (int i = 0; i < 5; i++) begin
      w = 8'($urandom);
      offer(w, acc);
      accbits[i] = acc;
    end
    chk("in_ready_pattern", accbits, 5'b01111);
    wait_idle();
    chk("pulse_count", pulses.size(), 5);
    if (pulses.size() >= 5)
      for (int i = 1; i < 5; i++)
        chk("issue_spacing", pulses[i] - pulses[i-1], LAT + 3);

    // host write to other register blocked in WB, retry lands next cycle
    hostw(2'd0, 4'd2);
    hostw(2'd1, 4'd6);
    hostw(2'd2, 4'd0);
    offer(8'b000_01_00_1, acc);
    wait_wb();
    reg_wr_en = 1'b1;
    reg_wr_addr = 2'd2;
    reg_wr_data = 4'hF;
    step();
    chk("wr_ready_after_wb", reg_wr_ready, 1);
    step();
    reg_wr_en = 1'b0;
    mr[2] = 4'hF;
    offer(8'b000_10_01_0, acc);
    wait_idle();

    // host write to rd in WB without retry: writeback value must remain
    offer(8'b001_01_00_1, acc);
    wait_wb();
    reg_wr_en = 1'b1;
    reg_wr_addr = 2'd1;
    reg_wr_data = 4'hF;
    step();
    reg_wr_en = 1'b0;
    offer(8'b101_01_01_0, acc);
    wait_idle();

    // reset during WAIT aborts the instruction
    hostw(2'd0, 4'd9);
    hostw(2'd1, 4'd4);
    offer(8'b000_00_01_1, acc);
    step();
    step();
    step();
    rst = 1'b1;
    sbq.delete();
    for (int i = 0; i < 4; i++) mr[i] = '0;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_A", A, 0);
    chk("abort_B", B, 0);
    chk("abort_instr", instr, 0);
    for (int i = 0; i < 6; i++) step();
    offer(8'b000_00_01_0, acc);
    wait_idle();

    // zero result followed by non-zero result
    hostw(2'd3, 4'd8);
    offer(8'b010_00_00_0, acc);
    offer(8'b011_11_00_0, acc);
    wait_idle();

    // randomized traffic; host writes only while drained
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        hostw(2'($urandom), 4'($urandom));
      end
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 3) != 0) offer(8'($urandom), acc);
        else step();
      end
    end
    wait_idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
